// File: rtl/intl_pkg.sv
// Shared definitions for the interlock fault manager: FSM states and sizing defaults.
package intl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FAULT = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  localparam int NCH_DEF    = 16;
  localparam int CNT_W_DEF  = 16;
  // Cycles spent in CLEAR so the upstream comparator pipeline flushes its stale flags.
  localparam int CLEAR_HOLD = 3;

endpackage

// File: rtl/intl_debounce.sv
// One channel's debounce: counts consecutive monitored-high cycles and requests a latch
// once the run reaches the configured length.
module intl_debounce #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flag,
  input  logic             i_mask,
  input  logic             i_hold,
  input  logic [CNT_W-1:0] i_deb_cnt,
  output logic             o_latch_req
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W:0]   cnt_inc_s;
  logic [CNT_W:0]   thr_s;
  logic             active_s;

  // Next count and latch request; a zero threshold is treated as one.
  always_comb begin
    active_s  = i_flag & i_mask;
    cnt_inc_s = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    if (i_deb_cnt == {CNT_W{1'b0}}) begin
      thr_s = {{CNT_W{1'b0}}, 1'b1};
    end else begin
      thr_s = {1'b0, i_deb_cnt};
    end
    if (i_hold || !active_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (&cnt_q) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_inc_s[CNT_W-1:0];
    end
    o_latch_req = active_s && !i_hold && (cnt_inc_s >= thr_s);
  end

  // Debounce counter register, cleared by the synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/intl_fault_manager.sv
// Interlock fault manager: debounces per-channel limit flags, latches sticky faults,
// records the first fault and its timestamp, and sequences the clear handshake.
module intl_fault_manager import intl_pkg::*; #(
  parameter int NCH   = NCH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  localparam int ID_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [NCH-1:0]   i_flag,
  input  logic [NCH-1:0]   i_mask,
  input  logic [CNT_W-1:0] i_deb_cnt,
  input  logic             i_clr,
  output logic             o_intl_clr,
  output logic             o_fault,
  output logic [NCH-1:0]   o_fault_vec,
  output logic [ID_W-1:0]  o_first_id,
  output logic [31:0]      o_first_ts,
  output logic [1:0]       o_state
);

  state_e          state_q;
  logic [1:0]      hold_cnt_q;
  logic [31:0]     ts_q;
  logic [NCH-1:0]  fault_vec_q;
  logic            fault_q;
  logic            intl_clr_q;
  logic [ID_W-1:0] first_id_q;
  logic [31:0]     first_ts_q;
  logic [NCH-1:0]  latch_req_s;
  logic            run_s;
  logic            hold_s;

  // Lowest set index wins when several channels latch together.
  function automatic logic [ID_W-1:0] lowest_idx(input logic [NCH-1:0] v);
    lowest_idx = {ID_W{1'b0}};
    for (int k = NCH - 1; k >= 0; k--) begin
      if (v[k]) begin
        lowest_idx = ID_W'(k);
      end
    end
  endfunction

  // Counters run only in IDLE/FAULT; a clear request (which wins over latching) zeroes them.
  always_comb begin
    run_s  = (state_q == ST_IDLE) || (state_q == ST_FAULT);
    hold_s = !run_s || i_clr;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    intl_debounce #(.CNT_W(CNT_W)) u_deb (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_flag      (i_flag[g]),
      .i_mask      (i_mask[g]),
      .i_hold      (hold_s),
      .i_deb_cnt   (i_deb_cnt),
      .o_latch_req (latch_req_s[g])
    );
  end

  // Fault FSM with timestamp counter, sticky fault vector and first-fault capture.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= ST_IDLE;
      hold_cnt_q  <= 2'd0;
      ts_q        <= 32'd0;
      fault_vec_q <= {NCH{1'b0}};
      fault_q     <= 1'b0;
      intl_clr_q  <= 1'b0;
      first_id_q  <= {ID_W{1'b0}};
      first_ts_q  <= 32'd0;
    end else begin
      ts_q       <= ts_q + 32'd1;
      intl_clr_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_FAULT: begin
          if (i_clr) begin
            state_q     <= ST_CLEAR;
            hold_cnt_q  <= 2'd0;
            fault_vec_q <= {NCH{1'b0}};
            fault_q     <= 1'b0;
            intl_clr_q  <= 1'b1;
          end else if (|latch_req_s) begin
            fault_vec_q <= fault_vec_q | latch_req_s;
            fault_q     <= 1'b1;
            if (state_q == ST_IDLE) begin
              state_q    <= ST_FAULT;
              first_id_q <= lowest_idx(latch_req_s);
              first_ts_q <= ts_q;
            end else begin
              state_q <= ST_FAULT;
            end
          end else begin
            fault_q <= |fault_vec_q;
          end
        end
        ST_CLEAR: begin
          if (hold_cnt_q == 2'(CLEAR_HOLD - 1)) begin
            state_q <= ST_IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q + 2'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_intl_clr  = intl_clr_q;
  assign o_fault     = fault_q;
  assign o_fault_vec = fault_vec_q;
  assign o_first_id  = first_id_q;
  assign o_first_ts  = first_ts_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_intl_fault_manager.sv
// Self-checking bench: per-cycle comparison against a run-length behavioural model,
// plus hand-computed expectations for the directed scenarios.
module tb_intl_fault_manager;

  localparam int NCH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] flag;
  logic [15:0] mask;
  logic [15:0] deb;
  logic        clr;
  logic        intl_clr;
  logic        fault;
  logic [15:0] fault_vec;
  logic [3:0]  first_id;
  logic [31:0] first_ts;
  logic [1:0]  state;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  intl_fault_manager dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flag      (flag),
    .i_mask      (mask),
    .i_deb_cnt   (deb),
    .i_clr       (clr),
    .o_intl_clr  (intl_clr),
    .o_fault     (fault),
    .o_fault_vec (fault_vec),
    .o_first_id  (first_id),
    .o_first_ts  (first_ts),
    .o_state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: run length of monitored-high cycles per channel, state as small ints.
  int          run [NCH];
  int          m_state;
  int          m_clr_left;
  logic [15:0] m_vec;
  logic [3:0]  m_first_id;
  logic [31:0] m_first_ts;
  logic [31:0] m_ts;
  logic        m_intl_clr;
  logic        m_fault;

  initial begin
    for (int k = 0; k < NCH; k++) run[k] = 0;
    m_state = 0; m_clr_left = 0; m_vec = 16'h0; m_first_id = 4'd0;
    m_first_ts = 32'd0; m_ts = 32'd0; m_intl_clr = 1'b0; m_fault = 1'b0;
  end

  always @(posedge clk) begin
    bit          clear_now;
    logic [15:0] newl;
    int          thr;
    if (!rst) begin
      for (int k = 0; k < NCH; k++) run[k] = 0;
      m_state = 0; m_clr_left = 0; m_vec = 16'h0; m_first_id = 4'd0;
      m_first_ts = 32'd0; m_ts = 32'd0; m_intl_clr = 1'b0; m_fault = 1'b0;
    end else begin
      clear_now = clr && (m_state != 2);
      thr  = (deb == 16'd0) ? 1 : int'(deb);
      newl = 16'h0;
      for (int k = 0; k < NCH; k++) begin
        if (m_state == 2 || clear_now || !(flag[k] && mask[k])) begin
          run[k] = 0;
        end else begin
          run[k] = run[k] + 1;
          if (run[k] >= thr) newl[k] = 1'b1;
        end
      end
      m_intl_clr = clear_now;
      if (clear_now) begin
        m_vec = 16'h0; m_state = 2; m_clr_left = 3;
      end else if (m_state == 2) begin
        m_clr_left = m_clr_left - 1;
        if (m_clr_left == 0) m_state = 0;
      end else if (newl != 16'h0) begin
        if (m_state == 0) begin
          for (int k = NCH - 1; k >= 0; k--) if (newl[k]) m_first_id = 4'(k);
          m_first_ts = m_ts;
          m_state = 1;
        end
        m_vec = m_vec | newl;
      end
      m_fault = (m_vec != 16'h0);
      m_ts = m_ts + 32'd1;
    end
  end

  // Per-cycle comparison of every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_state",     {30'd0, state},     32'(m_state));
      check("model_fault_vec", {16'd0, fault_vec}, {16'd0, m_vec});
      check("model_fault",     {31'd0, fault},     {31'd0, m_fault});
      check("model_intl_clr",  {31'd0, intl_clr},  {31'd0, m_intl_clr});
      check("model_first_id",  {28'd0, first_id},  {28'd0, m_first_id});
      check("model_first_ts",  first_ts,           m_first_ts);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; flag = 16'h0; mask = 16'hFFFF; deb = 16'd4; clr = 1'b0;
    step(3);
    chk_en = 1'b1;
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_vec", {16'd0, fault_vec}, 32'd0);
    check("rst_ts", first_ts, 32'd0);
    rst = 1'b1;

    // Scenario 1: short burst rejected, full burst of 4 latches channel 3.
    flag = 16'h0008; step(3);
    flag = 16'h0000; step(2);
    check("s1_burst1_vec", {16'd0, fault_vec}, 32'd0);
    flag = 16'h0008; step(3);
    check("s1_burst2_early", {16'd0, fault_vec}, 32'd0);
    step(1);
    check("s1_vec", {16'd0, fault_vec}, 32'h0008);
    check("s1_id", {28'd0, first_id}, 32'd3);
    check("s1_ts", first_ts, 32'd8);
    check("s1_state", {30'd0, state}, 32'd1);
    flag = 16'h0000;

    // Scenario 3: clear from FAULT with flags low.
    clr = 1'b1; step(1); clr = 1'b0;
    check("s3_intl_clr", {31'd0, intl_clr}, 32'd1);
    check("s3_state0", {30'd0, state}, 32'd2);
    check("s3_fault", {31'd0, fault}, 32'd0);
    step(1);
    check("s3_intl_clr_off", {31'd0, intl_clr}, 32'd0);
    check("s3_state1", {30'd0, state}, 32'd2);
    step(1);
    check("s3_state2", {30'd0, state}, 32'd2);
    step(1);
    check("s3_idle", {30'd0, state}, 32'd0);
    check("s3_id_kept", {28'd0, first_id}, 32'd3);
    check("s3_ts_kept", first_ts, 32'd8);

    // Scenario 2: two channels latch together with threshold 1.
    deb = 16'd1; flag = 16'h0300; step(1); flag = 16'h0000;
    check("s2_vec", {16'd0, fault_vec}, 32'h0300);
    check("s2_id", {28'd0, first_id}, 32'd8);
    check("s2_ts", first_ts, 32'd13);

    // Scenario 4: clear with channel 0 stuck high re-latches after CLEAR.
    deb = 16'd2; flag = 16'h0001; clr = 1'b1; step(1); clr = 1'b0;
    check("s4_vec_cleared", {16'd0, fault_vec}, 32'd0);
    step(3);
    check("s4_idle", {30'd0, state}, 32'd0);
    step(1);
    check("s4_not_yet", {16'd0, fault_vec}, 32'd0);
    step(1);
    check("s4_vec", {16'd0, fault_vec}, 32'h0001);
    check("s4_id", {28'd0, first_id}, 32'd0);
    check("s4_ts", first_ts, 32'd19);
    flag = 16'h0000;

    // Scenario 6: clear coincident with a completing latch, clear ignored in CLEAR, reset mid-CLEAR.
    clr = 1'b1; step(1); clr = 1'b0; step(3);
    flag = 16'h0004; step(1);
    clr = 1'b1; step(1);
    check("s6_lost_vec", {16'd0, fault_vec}, 32'd0);
    check("s6_state", {30'd0, state}, 32'd2);
    check("s6_ts_kept", first_ts, 32'd19);
    flag = 16'h0000; step(1); clr = 1'b0;
    check("s6_clr_ignored", {31'd0, intl_clr}, 32'd0);
    rst = 1'b0; step(1);
    check("s6_rst_state", {30'd0, state}, 32'd0);
    check("s6_rst_ts", first_ts, 32'd0);
    check("s6_rst_clr", {31'd0, intl_clr}, 32'd0);
    rst = 1'b1;

    // Reset mid-debounce discards the partial count.
    deb = 16'd3; flag = 16'h0002; step(2);
    rst = 1'b0; step(1); rst = 1'b1; step(2);
    check("rd_partial", {16'd0, fault_vec}, 32'd0);
    step(1);
    check("rd_vec", {16'd0, fault_vec}, 32'h0002);
    check("rd_ts", first_ts, 32'd2);
    flag = 16'h0000;

    // Scenario 5: masked-out channel never latches.
    clr = 1'b1; step(1); clr = 1'b0; step(3);
    deb = 16'd1; mask = 16'hFFDF; flag = 16'h0020; step(100);
    check("s5_state", {30'd0, state}, 32'd0);
    check("s5_vec", {16'd0, fault_vec}, 32'd0);
    flag = 16'h0000; mask = 16'hFFFF;

    // Threshold 0 behaves as 1.
    deb = 16'd0; flag = 16'h8000; step(1); flag = 16'h0000;
    check("d0_vec", {16'd0, fault_vec}, 32'h8000);
    check("d0_id", {28'd0, first_id}, 32'd15);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
